// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe delay line.
// Output taps are added when DFF_PIPE_TAPS_EN is defined.
package dff_pipe_pkg;

    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/valid/stall bundle for dff_pipe; taps appear when DFF_PIPE_TAPS_EN is defined.
// Handshake: en=1 advances every stage by one word; no back-pressure, in_valid qualifies d.
interface dff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = dff_pipe_pkg::occ_width(DEPTH);

    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [CW-1:0]    occupancy;
`ifdef DFF_PIPE_TAPS_EN
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_valid;

    modport master (output en, flush, in_valid, d,
                    input  q, out_valid, occupancy, taps, tap_valid);
    modport slave  (input  en, flush, in_valid, d,
                    output q, out_valid, occupancy, taps, tap_valid);
`else
    modport master (output en, flush, in_valid, d,
                    input  q, out_valid, occupancy);
    modport slave  (input  en, flush, in_valid, d,
                    output q, out_valid, occupancy);
`endif
endinterface

// File: rtl/dff_stage.sv
// One data+valid register with rst > flush > en > hold priority.
module dff_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             vld_in,
    output logic [WIDTH-1:0] q,
    output logic             vld_out
);

    // Flush only kills the valid bit; the data word is left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            vld_out <= 1'b0;
        end else if (flush) begin
            vld_out <= 1'b0;
        end else if (en) begin
            q       <= d;
            vld_out <= vld_in;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage delay line with valid, stall, flush and occupancy count.
// Define DFF_PIPE_TAPS_EN to expose every stage on taps/tap_valid.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic       clk,
    input  logic       rst,
    dff_pipe_if.slave  bus
);

    localparam int CW = occ_width(DEPTH);

    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] d_in [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] v_in;
    logic [CW-1:0]    occ;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign d_in[i] = bus.d;
            assign v_in[i] = bus.in_valid;
        end else begin : g_body
            assign d_in[i] = data[i-1];
            assign v_in[i] = vld[i-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .flush   (bus.flush),
            .d       (d_in[i]),
            .vld_in  (v_in[i]),
            .q       (data[i]),
            .vld_out (vld[i])
        );

`ifdef DFF_PIPE_TAPS_EN
        assign bus.taps[i*WIDTH +: WIDTH] = data[i];
`endif
    end

    // A word entering and a word leaving on the same advance cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (bus.flush) begin
            occ <= '0;
        end else if (bus.en) begin
            occ <= occ + CW'(bus.in_valid) - CW'(vld[DEPTH-1]);
        end
    end

    assign bus.q         = data[DEPTH-1];
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.occupancy = occ;
`ifdef DFF_PIPE_TAPS_EN
    assign bus.tap_valid = vld;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(occ) == $countones(vld));
            assert (int'(occ) <= DEPTH);
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed vectors, stall/reset sequences and random traffic vs a queue model.
module tb_dff_pipe;
    localparam logic [7:0] RV4 = 8'hA5;
    localparam logic [7:0] RV1 = 8'h3C;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
    dff_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: front of each queue is stage 0
    logic [7:0] exp_q[$];
    logic       exp_v[$];
    logic [7:0] exp_q1[$];
    logic       exp_v1[$];

    typedef struct {
        logic       rst, en, flush, iv;
        logic [7:0] d;
        logic [7:0] eq;
        logic       eov;
        logic [2:0] eocc;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, e, f, iv, input logic [7:0] d,
                                input logic [7:0] eq, input logic eov, input logic [2:0] eocc);
        vec_t v;
        v.rst = r; v.en = e; v.flush = f; v.iv = iv; v.d = d;
        v.eq = eq; v.eov = eov; v.eocc = eocc;
        return v;
    endfunction

    // driver: apply one cycle to both DUTs, advance the model, compare everything
    task automatic drive(input logic r, e, f, iv, input logic [7:0] dd);
        int occ4;
        int occ1;
        logic [31:0] et;
        logic [3:0]  etv;
        rst = r;
        bus4.en = e; bus4.flush = f; bus4.in_valid = iv; bus4.d = dd;
        bus1.en = e; bus1.flush = f; bus1.in_valid = iv; bus1.d = dd;
        @(posedge clk);
        #1;
        if (r) begin
            foreach (exp_q[i]) begin exp_q[i] = RV4; exp_v[i] = 1'b0; end
            exp_q1[0] = RV1; exp_v1[0] = 1'b0;
        end else if (f) begin
            foreach (exp_v[i]) exp_v[i] = 1'b0;
            exp_v1[0] = 1'b0;
        end else if (e) begin
            exp_q.push_front(dd);  exp_v.push_front(iv);
            void'(exp_q.pop_back()); void'(exp_v.pop_back());
            exp_q1.push_front(dd); exp_v1.push_front(iv);
            void'(exp_q1.pop_back()); void'(exp_v1.pop_back());
        end
        occ4 = 0;
        foreach (exp_v[i]) occ4 += int'(exp_v[i]);
        occ1 = int'(exp_v1[0]);
        check("q4", 32'(bus4.q), 32'(exp_q[3]));
        check("out_valid4", 32'(bus4.out_valid), 32'(exp_v[3]));
        check("occupancy4", 32'(bus4.occupancy), 32'(occ4));
        check("q1", 32'(bus1.q), 32'(exp_q1[0]));
        check("out_valid1", 32'(bus1.out_valid), 32'(exp_v1[0]));
        check("occupancy1", 32'(bus1.occupancy), 32'(occ1));
`ifdef DFF_PIPE_TAPS_EN
        et = '0;
        etv = '0;
        foreach (exp_q[i]) begin et[i*8 +: 8] = exp_q[i]; etv[i] = exp_v[i]; end
        check("taps4", bus4.taps, et);
        check("tap_valid4", 32'(bus4.tap_valid), 32'(etv));
        check("taps1", 32'(bus1.taps), 32'(exp_q1[0]));
        check("tap_valid1", 32'(bus1.tap_valid), 32'(exp_v1[0]));
`else
        et = '0;
        etv = '0;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus4.en = 0; bus4.flush = 0; bus4.in_valid = 0; bus4.d = '0;
        bus1.en = 0; bus1.flush = 0; bus1.in_valid = 0; bus1.d = '0;
        for (int i = 0; i < 4; i++) begin exp_q.push_back('0); exp_v.push_back(1'b0); end
        exp_q1.push_back('0); exp_v1.push_back(1'b0);

        // reset, straight stream, flush of a full pipe, alternating valid
        vecs.push_back(mk(1,0,0,0,8'h00, 8'hA5,0,0));
        vecs.push_back(mk(1,0,0,0,8'h00, 8'hA5,0,0));
        vecs.push_back(mk(0,1,0,1,8'h01, 8'hA5,0,1));
        vecs.push_back(mk(0,1,0,1,8'h02, 8'hA5,0,2));
        vecs.push_back(mk(0,1,0,1,8'h03, 8'hA5,0,3));
        vecs.push_back(mk(0,1,0,1,8'h04, 8'h01,1,4));
        vecs.push_back(mk(0,1,0,1,8'h05, 8'h02,1,4));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h03,1,3));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h04,1,2));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h05,1,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h00,0,0));
        vecs.push_back(mk(0,1,0,1,8'h31, 8'h00,0,1));
        vecs.push_back(mk(0,1,0,1,8'h32, 8'h00,0,2));
        vecs.push_back(mk(0,1,0,1,8'h33, 8'h00,0,3));
        vecs.push_back(mk(0,1,0,1,8'h34, 8'h31,1,4));
        vecs.push_back(mk(0,1,1,1,8'h77, 8'h31,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h32,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h33,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h34,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 8'h00,0,0));
        vecs.push_back(mk(0,1,0,1,8'd10, 8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'd11, 8'h00,0,1));
        vecs.push_back(mk(0,1,0,1,8'd12, 8'h00,0,2));
        vecs.push_back(mk(0,1,0,0,8'd13, 8'd10,1,2));
        vecs.push_back(mk(0,1,0,1,8'd14, 8'd11,0,2));
        vecs.push_back(mk(0,1,0,0,8'd15, 8'd12,1,2));
        vecs.push_back(mk(0,1,0,1,8'd16, 8'd13,0,2));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].iv, vecs[i].d);
            check($sformatf("vec%0d_q", i), 32'(bus4.q), 32'(vecs[i].eq));
            check($sformatf("vec%0d_ov", i), 32'(bus4.out_valid), 32'(vecs[i].eov));
            check($sformatf("vec%0d_occ", i), 32'(bus4.occupancy), 32'(vecs[i].eocc));
        end

        // stall for 3 cycles after d=2 is captured
        drive(1,0,0,0,8'h00);
        got.delete();
        drive(0,1,0,1,8'h01);
        drive(0,1,0,1,8'h02);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,1,8'h99);
            check("stall_q", 32'(bus4.q), 32'(RV4));
            check("stall_ov", 32'(bus4.out_valid), 32'd0);
            check("stall_occ", 32'(bus4.occupancy), 32'd2);
        end
        for (int i = 3; i <= 5; i++) begin
            drive(0,1,0,1,8'(i));
            if (bus4.out_valid) got.push_back(bus4.q);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0,1,0,0,8'h00);
            if (bus4.out_valid) got.push_back(bus4.q);
        end
        check("stall_stream_len", 32'(got.size()), 32'd5);
        foreach (got[i]) check("stall_stream", 32'(got[i]), 32'(i + 1));

        // reset in the same cycle as a valid advance with three words in flight
        drive(1,0,0,0,8'h00);
        drive(0,1,0,1,8'h41);
        drive(0,1,0,1,8'h42);
        drive(0,1,0,1,8'h43);
        check("pre_rst_occ", 32'(bus4.occupancy), 32'd3);
        drive(1,1,0,1,8'hEE);
        check("mid_rst_q4", 32'(bus4.q), 32'(RV4));
        check("mid_rst_occ4", 32'(bus4.occupancy), 32'd0);
        check("mid_rst_q1", 32'(bus1.q), 32'(RV1));
        check("mid_rst_ov1", 32'(bus1.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0,1,0,0,8'h00);
            check("post_rst_ov4", 32'(bus4.out_valid), 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0,49) == 0, $urandom_range(0,3) != 0,
                  $urandom_range(0,19) == 0, 1'($urandom_range(0,1)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
